// File: rtl/mul_shift_add_32.sv
// Multi-cycle unsigned WIDTHxWIDTH shift-add multiplier that borrows the shared
// external ripple adder for its one add per iteration; start/busy/done handshake.
module mul_shift_add_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH:0]     add_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;

    // The carry out lands in hi's MSB through the shift, so nothing is ever lost.
    assign hi_nxt    = add_s[WIDTH:1];
    assign lo_nxt    = {add_s[0], lo[WIDTH-1:1]};
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    assign add_a = hi;
    assign add_b = lo[0] ? mcand : '0;

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        lo    <= b;
                        hi    <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product <= {hi_nxt, lo_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
